priority_n_iter: RTL

//  Parametrised iterative successor of the single-winner priority encoder in cluster building.

---
 rtl/priority_n_iter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/priority_n_iter.sv
// Iterative lowest-index priority encoder: snapshots a pad-valid vector and emits up to MXOUT hits.
// Optional overflow reporting (overflow_o, ndropped_o) is compiled in with PRIORITY_OVERFLOW_EN.
module priority_n_iter #(
   parameter int MXKEYS    = 384,
   parameter int MXKEYBITS = 9,
   parameter int MXCNTB    = 3,
   parameter int MXOUT     = 8,
   parameter int MXOUTB    = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       load_i,
   input  logic [MXKEYS-1:0]          vpfs_i,
   input  logic [MXKEYS*MXCNTB-1:0]   cnts_i,
   input  logic                       ready_i,
   output logic                       busy_o,
   output logic                       valid_o,
   output logic [MXKEYBITS-1:0]       adr_o,
   output logic [MXCNTB-1:0]          cnt_o,
   output logic                       last_o,
   output logic                       done_o,
   output logic [MXOUTB-1:0]          nfound_o,
   output logic                       overflow_o,
   output logic [MXOUTB-1:0]          ndropped_o
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [MXOUTB-1:0] LP_MXOUT = MXOUTB'(MXOUT);
   localparam logic [MXKEYS-1:0] LP_ONE   = {{(MXKEYS-1){1'b0}}, 1'b1};

   state_t                     r_state;
   logic [MXKEYS-1:0]          r_snap;
   logic [MXKEYS*MXCNTB-1:0]   r_cnts;
   logic [MXOUTB-1:0]          r_emitted;
   logic                       r_busy;
   logic                       r_valid;
   logic [MXKEYBITS-1:0]       r_adr;
   logic [MXCNTB-1:0]          r_cnt;
   logic                       r_last;
   logic                       r_done;
   logic [MXOUTB-1:0]          r_nfound;

   logic                       w_any;
   logic [MXKEYBITS-1:0]       w_idx;
   logic [MXCNTB-1:0]          w_cntSel;
   logic [MXKEYS-1:0]          w_snapClr;
   logic                       w_moreAfter;
   logic [MXOUTB-1:0]          w_emittedNext;
   logic                       w_finish;
   logic                       w_advance;

   // Scanning from the top down lets the lowest set index overwrite the result last.
   always_comb begin
      w_any    = 1'b0;
      w_idx    = '1;
      w_cntSel = '0;
      for (int k = MXKEYS-1; k >= 0; k--) begin
         if (r_snap[k]) begin
            w_any    = 1'b1;
            w_idx    = MXKEYBITS'(k);
            w_cntSel = r_cnts[k*MXCNTB +: MXCNTB];
         end
      end
   end

   assign w_snapClr     = r_snap & ~(LP_ONE << w_idx);
   assign w_moreAfter   = |w_snapClr;
   assign w_emittedNext = r_emitted + 1'b1;
   assign w_advance     = !r_valid || ready_i;
   // Either the final hit is being accepted, or the load arrived empty.
   assign w_finish      = (r_valid && ready_i && r_last) || (!r_valid && !w_any);

`ifdef PRIORITY_OVERFLOW_EN
   localparam logic [MXOUTB-1:0] LP_SAT = '1;

   logic                  r_overflow;
   logic [MXOUTB-1:0]     r_ndropped;
   logic [MXKEYBITS:0]    w_pop;
   logic [MXOUTB-1:0]     w_dropped;

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < MXKEYS; k++) begin
         w_pop = w_pop + (MXKEYBITS+1)'(r_snap[k]);
      end
   end

   assign w_dropped  = (w_pop > (MXKEYBITS+1)'(LP_SAT)) ? LP_SAT : w_pop[MXOUTB-1:0];
   assign overflow_o = r_overflow;
   assign ndropped_o = r_ndropped;
`else
   assign overflow_o = 1'b0;
   assign ndropped_o = '0;
`endif

   // Whole controller, including the output register and the snapshot mask.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_snap    <= '0;
         r_cnts    <= '0;
         r_emitted <= '0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_adr     <= '1;
         r_cnt     <= '0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_nfound  <= '0;
`ifdef PRIORITY_OVERFLOW_EN
         r_overflow <= 1'b0;
         r_ndropped <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (load_i) begin
                  r_snap    <= vpfs_i;
                  r_cnts    <= cnts_i;
                  r_emitted <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= SCAN;
               end
            end
            SCAN: begin
               if (w_finish) begin
                  r_valid  <= 1'b0;
                  r_last   <= 1'b0;
                  r_done   <= 1'b1;
                  r_nfound <= r_emitted;
                  r_state  <= DONE;
`ifdef PRIORITY_OVERFLOW_EN
                  r_overflow <= w_any;
                  r_ndropped <= w_dropped;
`endif
               end else if (w_advance) begin
                  if (w_any && (r_emitted < LP_MXOUT)) begin
                     r_valid   <= 1'b1;
                     r_adr     <= w_idx;
                     r_cnt     <= w_cntSel;
                     r_last    <= !w_moreAfter || (w_emittedNext == LP_MXOUT);
                     r_snap    <= w_snapClr;
                     r_emitted <= w_emittedNext;
                  end else begin
                     r_valid <= 1'b0;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy_o   = r_busy;
   assign valid_o  = r_valid;
   assign adr_o    = r_adr;
   assign cnt_o    = r_cnt;
   assign last_o   = r_last;
   assign done_o   = r_done;
   assign nfound_o = r_nfound;

endmodule
